// File: rtl/peripheral_mpi_bb_initiator.sv
// BlackBone initiator for an MPI endpoint: stages tx messages, polls and drains rx.
// Optional PERIPHERAL_MPI_BB_INITIATOR_IRQ_EN replaces timed polling with an irq_i trigger.
module peripheral_mpi_bb_initiator #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          SIZE          = 16,
  parameter int          POLL_INTERVAL = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] bb_addr_o,
  output logic [31:0] bb_din_o,
  output logic        bb_en_o,
  output logic        bb_we_o,
  input  logic [31:0] bb_dout_i,
  input  logic        irq_i,
  input  logic [31:0] tx_flit,
  input  logic        tx_last,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_flit,
  output logic        rx_last,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        tx_overflow
);

  localparam int CW = $clog2(SIZE + 1);
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [31:0] A_DATA = BASE_ADDR;
  localparam logic [31:0] A_STAT = BASE_ADDR + 32'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_POLL, S_POLL_W, S_RSIZE, S_RSIZE_W, S_RDATA,
    S_RDATA_W, S_ROUT, S_TSTAT, S_TSTAT_W, S_TSIZE, S_TDATA
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic [31:0] r_buf [SIZE];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_idx;
  logic        r_staged;
  logic        r_ovf;
  logic        r_phase;
  logic [15:0] r_rem;
  logic [31:0] r_rx_flit;
  logic        r_rx_valid;
  logic        r_rx_last;
  logic        r_tx_ready;

  logic        w_en;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_din;
  logic        w_clear;
  logic        w_hs;
  logic        w_poll_due;
  logic        w_staged_nxt;
  logic        w_tx_nxt;

  assign w_hs = tx_valid & r_tx_ready;

`ifdef PERIPHERAL_MPI_BB_INITIATOR_IRQ_EN
  assign w_poll_due = irq_i;
`else
  localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  logic [PW-1:0] r_poll;
  logic          w_unused_irq;

  assign w_unused_irq = irq_i;
  assign w_poll_due   = (r_poll == PW'(POLL_INTERVAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_poll <= '0;
    end else if (r_state == S_IDLE) begin
      r_poll <= w_poll_due ? '0 : r_poll + PW'(1);
    end
  end
`endif

  always_comb begin
    w_nxt   = r_state;
    w_en    = 1'b0;
    w_we    = 1'b0;
    w_addr  = 32'd0;
    w_din   = 32'd0;
    w_clear = 1'b0;
    unique case (r_state)
      // rx poll takes priority so the network never stalls on our tx
      S_IDLE: begin
        if (w_poll_due) begin
          w_nxt = S_POLL;
        end else if (r_staged) begin
          w_nxt = S_TSTAT;
        end
      end
      S_POLL: begin
        w_en   = 1'b1;
        w_addr = A_STAT;
        w_nxt  = S_POLL_W;
      end
      S_POLL_W: w_nxt = bb_dout_i[0] ? S_RSIZE : S_IDLE;
      S_RSIZE: begin
        w_en   = 1'b1;
        w_addr = A_DATA;
        w_nxt  = S_RSIZE_W;
      end
      S_RSIZE_W: w_nxt = (bb_dout_i[15:0] == 16'd0) ? S_IDLE : S_RDATA;
      S_RDATA: begin
        w_en   = 1'b1;
        w_addr = A_DATA;
        w_nxt  = S_RDATA_W;
      end
      S_RDATA_W: w_nxt = S_ROUT;
      S_ROUT: begin
        if (rx_ready) begin
          w_nxt = (r_rem == 16'd1) ? S_IDLE : S_RDATA;
        end
      end
      S_TSTAT: begin
        w_en   = 1'b1;
        w_addr = A_STAT;
        w_nxt  = S_TSTAT_W;
      end
      S_TSTAT_W: w_nxt = bb_dout_i[1] ? S_TSIZE : S_IDLE;
      S_TSIZE: begin
        w_en   = 1'b1;
        w_we   = 1'b1;
        w_addr = A_DATA;
        w_din  = 32'(r_cnt);
        w_nxt  = S_TDATA;
      end
      // r_phase=0 is the mandatory idle gap between strobes
      S_TDATA: begin
        if (r_phase) begin
          w_en   = 1'b1;
          w_we   = 1'b1;
          w_addr = A_DATA;
          w_din  = r_buf[r_idx[IW-1:0]];
          if (r_idx == r_cnt - CW'(1)) begin
            w_clear = 1'b1;
            w_nxt   = S_IDLE;
          end
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_staged_nxt = w_clear ? 1'b0 : (r_staged | (w_hs & tx_last));
  assign w_tx_nxt     = (w_nxt == S_TSTAT) || (w_nxt == S_TSTAT_W) ||
                        (w_nxt == S_TSIZE) || (w_nxt == S_TDATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_phase    <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_staged   <= 1'b0;
      r_ovf      <= 1'b0;
      r_tx_ready <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_phase    <= (r_state == S_TDATA) ? ~r_phase : 1'b0;
      r_tx_ready <= ~w_staged_nxt & ~w_tx_nxt;
      if (r_state != S_TDATA) begin
        r_idx <= '0;
      end else if (r_phase) begin
        r_idx <= r_idx + CW'(1);
      end
      if (w_clear) begin
        r_cnt    <= '0;
        r_staged <= 1'b0;
      end else if (w_hs) begin
        if (r_cnt < CW'(SIZE)) begin
          r_cnt <= r_cnt + CW'(1);
        end else begin
          r_ovf <= 1'b1;
        end
        if (tx_last) begin
          r_staged <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && (r_cnt < CW'(SIZE))) begin
      r_buf[r_cnt[IW-1:0]] <= tx_flit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem      <= 16'd0;
      r_rx_flit  <= 32'd0;
      r_rx_valid <= 1'b0;
      r_rx_last  <= 1'b0;
    end else begin
      unique case (r_state)
        S_RSIZE_W: r_rem <= bb_dout_i[15:0];
        S_RDATA_W: begin
          r_rx_flit  <= bb_dout_i;
          r_rx_valid <= 1'b1;
          r_rx_last  <= (r_rem == 16'd1);
        end
        S_ROUT: begin
          if (rx_ready) begin
            r_rx_valid <= 1'b0;
            r_rx_last  <= 1'b0;
            r_rem      <= r_rem - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bb_en_o     = w_en;
  assign bb_we_o     = w_we;
  assign bb_addr_o   = w_addr;
  assign bb_din_o    = w_din;
  assign tx_ready    = r_tx_ready;
  assign rx_flit     = r_rx_flit;
  assign rx_valid    = r_rx_valid;
  assign rx_last     = r_rx_last;
  assign tx_overflow = r_ovf;

endmodule

// File: tb/tb_peripheral_mpi_bb_initiator.sv
// Directed bench for peripheral_mpi_bb_initiator with a behavioural MPI endpoint.
module tb_peripheral_mpi_bb_initiator;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int SZ = 4;
  localparam int PI = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bb_addr_o;
  logic [31:0] bb_din_o;
  logic        bb_en_o;
  logic        bb_we_o;
  logic [31:0] bb_dout_i = 32'd0;
  logic        irq_i;
  logic [31:0] tx_flit;
  logic        tx_last;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_flit;
  logic        rx_last;
  logic        rx_valid;
  logic        rx_ready;
  logic        tx_overflow;

  peripheral_mpi_bb_initiator #(
    .BASE_ADDR(BASE), .SIZE(SZ), .POLL_INTERVAL(PI)
  ) dut (
    .clk(clk), .rst(rst),
    .bb_addr_o(bb_addr_o), .bb_din_o(bb_din_o),
    .bb_en_o(bb_en_o), .bb_we_o(bb_we_o),
    .bb_dout_i(bb_dout_i), .irq_i(irq_i),
    .tx_flit(tx_flit), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_flit(rx_flit), .rx_last(rx_last),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_wr[$];
  logic [32:0] exp_rx[$];
  logic [31:0] rx_q[$];
  logic        tx_space = 1'b0;
  logic        prev_en = 1'b0;
  int          rd0 = 0;
  int          t_seq = 0;
  int          f_seq = 0;
  int          t_mon = 0;
  int          f_mon = 0;

  // endpoint model and output scoreboard
  always @(negedge clk) begin
    logic [31:0] e;
    logic [32:0] r;
    if (bb_en_o) begin
      t_mon++;
      assert (!prev_en) else begin
        f_mon++;
        $error("FAIL bus_gap: got back-to-back strobe, expected idle cycle");
      end
      if (bb_we_o) begin
        t_mon++;
        assert (exp_wr.size() != 0) else begin
          f_mon++;
          $error("FAIL bus_wr_unexp: got %h@%h expected no write", bb_din_o, bb_addr_o);
        end
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          t_mon++;
          assert ({bb_addr_o, bb_din_o} === {BASE, e}) else begin
            f_mon++;
            $error("FAIL bus_wr: got %h@%h expected %h@%h", bb_din_o, bb_addr_o, e, BASE);
          end
        end
      end else begin
        t_mon++;
        assert (bb_addr_o === BASE || bb_addr_o === BASE + 32'd4) else begin
          f_mon++;
          $error("FAIL bus_rd_addr: got %h expected %h or %h", bb_addr_o, BASE, BASE + 32'd4);
        end
        if (bb_addr_o == BASE + 32'd4) begin
          bb_dout_i = {30'd0, tx_space, rx_q.size() != 0};
        end else begin
          rd0++;
          bb_dout_i = (rx_q.size() != 0) ? rx_q.pop_front() : 32'd0;
        end
      end
    end
    prev_en = bb_en_o;
    if (rx_valid && rx_ready) begin
      t_mon++;
      assert (exp_rx.size() != 0) else begin
        f_mon++;
        $error("FAIL rx_unexp: got %h last=%b expected nothing", rx_flit, rx_last);
      end
      if (exp_rx.size() != 0) begin
        r = exp_rx.pop_front();
        t_mon++;
        assert ({rx_last, rx_flit} === r) else begin
          f_mon++;
          $error("FAIL rx_word: got %h expected %h", {rx_last, rx_flit}, r);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    t_seq++;
    assert (got === exp) else begin
      f_seq++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    tx_flit  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("tx_accept", {63'd0, tx_ready}, 64'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic wait_wr_done(input string tag);
    int n;
    n = 0;
    while (exp_wr.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(exp_wr.size()), 64'd0);
  endtask

  task automatic wait_rx_done(input string tag);
    int n;
    n = 0;
    while (exp_rx.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(exp_rx.size()), 64'd0);
  endtask

  initial begin
    int n;
    int rd_snap;
    rst      = 1'b1;
    irq_i    = 1'b0;
    tx_flit  = 32'd0;
    tx_last  = 1'b0;
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bus", {bb_en_o, bb_we_o, bb_addr_o, bb_din_o}, 64'd0);
    chk("rst_flags", {60'd0, tx_ready, rx_valid, rx_last, tx_overflow}, 64'd0);
    chk("rst_rx_flit", {32'd0, rx_flit}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_after_rst", {63'd0, tx_ready}, 64'd1);

    // 3-word tx message
    tx_space = 1'b1;
    exp_wr.push_back(32'd3);
    exp_wr.push_back(32'hA);
    exp_wr.push_back(32'hB);
    exp_wr.push_back(32'hC);
    send_word(32'hA, 1'b0);
    send_word(32'hB, 1'b0);
    send_word(32'hC, 1'b1);
    wait_wr_done("tx3_writes");
    repeat (2) @(negedge clk);
    chk("tx3_ready_back", {63'd0, tx_ready}, 64'd1);

    // rx message with back-pressure on the first word
    rx_ready = 1'b0;
    rx_q.push_back(32'd2);
    rx_q.push_back(32'h11);
    rx_q.push_back(32'h22);
    exp_rx.push_back({1'b0, 32'h11});
    exp_rx.push_back({1'b1, 32'h22});
    n = 0;
    while (!rx_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("rx_stall_hold", {30'd0, rx_valid, rx_last, rx_flit}, {30'd0, 1'b1, 1'b0, 32'h11});
      @(negedge clk);
    end
    rx_ready = 1'b1;
    wait_rx_done("rx2_drain");
    @(negedge clk);
    chk("rx2_valid_low", {63'd0, rx_valid}, 64'd0);

    // overflow: 6 words into a 4-word buffer
    exp_wr.push_back(32'd4);
    for (int i = 0; i < 4; i++) exp_wr.push_back(32'h100 + 32'(i));
    for (int i = 0; i < 6; i++) send_word(32'h100 + 32'(i), i == 5);
    wait_wr_done("ovf_writes");
    chk("ovf_flag", {63'd0, tx_overflow}, 64'd1);

    // zero-length rx message
    rd_snap = rd0;
    rx_q.push_back(32'd0);
    n = 0;
    while (rx_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3 * PI) @(negedge clk);
    chk("rx0_reads", 64'(rd0 - rd_snap), 64'd1);
    chk("rx0_no_valid", {63'd0, rx_valid}, 64'd0);

    // rx poll must win over a staged tx that keeps getting refused
    tx_space = 1'b0;
    exp_wr.push_back(32'd2);
    exp_wr.push_back(32'h55);
    exp_wr.push_back(32'h66);
    send_word(32'h55, 1'b0);
    send_word(32'h66, 1'b1);
    rx_q.push_back(32'd1);
    rx_q.push_back(32'h77);
    exp_rx.push_back({1'b1, 32'h77});
    wait_rx_done("prio_rx_served");
    chk("prio_tx_pending", 64'(exp_wr.size()), 64'd3);
    tx_space = 1'b1;
    wait_wr_done("prio_tx_writes");
    chk("ovf_sticky", {63'd0, tx_overflow}, 64'd1);

    // reset in the middle of TDATA
    exp_wr.push_back(32'd3);
    exp_wr.push_back(32'h1);
    exp_wr.push_back(32'h2);
    exp_wr.push_back(32'h3);
    send_word(32'h1, 1'b0);
    send_word(32'h2, 1'b0);
    send_word(32'h3, 1'b1);
    n = 0;
    while (exp_wr.size() > 2 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_tx_progress", 64'(exp_wr.size()), 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_bus", {bb_en_o, bb_we_o, bb_addr_o, bb_din_o}, 64'd0);
    chk("mid_rst_flags", {60'd0, tx_ready, rx_valid, rx_last, tx_overflow}, 64'd0);
    chk("mid_rst_rx_flit", {32'd0, rx_flit}, 64'd0);
    exp_wr.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_ready", {63'd0, tx_ready}, 64'd1);
    exp_wr.push_back(32'd1);
    exp_wr.push_back(32'h99);
    send_word(32'h99, 1'b1);
    wait_wr_done("post_rst_clean");

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", t_seq + t_mon, f_seq + f_mon);
    $finish;
  end

endmodule
